ahb_bram_ctrl: RTL and testbench
================================

Name: ahb_bram_ctrl

Overview:
AHB-Lite slave that connects the Cortex-M0 system bus to the dual-port Block_RAM (write port A, registered read port B). It decodes AHB-Lite transfers into word addresses, byte-lane write strobes and read addresses. Single reads and writes complete with zero wait states. A read that follows a write to the same word costs one wait state, or none when forwarding is compiled in. Illegal sizes and alignments get a two-cycle ERROR response. The block sits between the bus matrix and the instruction/data RAM.

Parameters:
ADDR_WIDTH, 14, word-address width of the attached RAM (RAM depth 2**ADDR_WIDTH words).

Ports:
clka  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
HSEL  in  1  slave select
HADDR  in  32  byte address; HADDR[ADDR_WIDTH+1:2] is the word index, upper bits ignored
HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer
HSIZE  in  3  0=byte, 1=halfword, 2=word, others illegal
HWRITE  in  1  1=write
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus-wide ready; an address phase is accepted only when high
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data
bram_addra  out  ADDR_WIDTH  RAM write address
bram_wea  out  4  RAM byte write enables
bram_dina  out  32  RAM write data
bram_addrb  out  ADDR_WIDTH  RAM read address
bram_doutb  in  32  RAM read data, one clka after bram_addrb

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, register the word address, lane mask, HWRITE and an error flag.
- Lane mask:
  - byte: 1<<HADDR[1:0]
  - halfword: 4'b0011 or 4'b1100, selected by HADDR[1]
  - word: 4'b1111
- Illegal transfers: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0. These set the error flag and never write the RAM.
- Write data phase: bram_addra = registered address, bram_dina = HWDATA, bram_wea = registered mask. These outputs are combinational from the registered state. The RAM updates at the end of the data-phase cycle. bram_wea=0 at all other times.
- Reads: bram_addrb = HADDR word index (combinational) during the address phase, so HRDATA = bram_doutb in the next cycle with zero wait.
- Hazard: a read address phase coincident with a write data phase to the same word index. The RAM then returns stale data.
  - Without forwarding: the read data phase drives HREADYOUT=0 for one cycle. bram_addrb is re-driven from the registered read address, and HRDATA is valid in the following cycle.
- FSM states:
  - IDLE: no data phase.
  - WR: write data phase.
  - RD: read data phase, HREADYOUT=1.
  - RD_STALL: hazard wait; HREADYOUT=0, returns to RD-completion next cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions: a new accept from WR, RD or ERR2 moves directly to the next data-phase state. No accept returns to IDLE. No accept is possible during RD_STALL or ERR1, because HREADY is low.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA follows bram_doutb, bram_wea=0, registered address/mask=0.
- Reset mid-transfer: abandons the data phase. A pending write is dropped (wea forced 0 while rst=1).
- HSEL low or IDLE/BUSY transfers: OKAY, zero wait, no RAM access.
- Address wrap: word index is taken modulo 2**ADDR_WIDTH.

Optional Feature:
BRAM_BYPASS_EN
- Defined: a hazard does not stall. Registered copies of the write data and mask are kept, and HRDATA merges the written lanes over bram_doutb byte-wise. RD_STALL is unreachable and HREADYOUT stays 1 for all OKAY transfers.
- Undefined: one-wait-state stall as described in Behaviour.

Decomposition:
- Package ahb_bram_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE encodings
  - HRESP encodings
  - FSM state enum
  - lane-mask function (size, addr[1:0]) -> {mask, illegal}
- Sub-module ahb_bram_lane_dec: combinational decode of lane mask and error flag. Everything else stays in the top.

Test Plan:
- Word write 0xDEADBEEF @0x0000_0010, then idle, then read @0x10 -> bram_wea=4'hF, addra=4; read HRDATA=0xDEADBEEF, HREADYOUT never low.
- Byte write 0xAB @0x13 over 0x11223344 -> wea=4'b1000; word read returns 0xAB223344.
- Back-to-back write 0x55667788 @0x20 then read @0x20 -> without macro, one cycle HREADYOUT=0 then 0x55667788; with BRAM_BYPASS_EN, zero wait and 0x55667788.
- Word access @0x22 or HSIZE=3 -> HREADYOUT 0 then 1 with HRESP=1 both cycles; RAM contents unchanged.
- Assert rst during a write data phase -> wea=0 that cycle, HREADYOUT=1, HRESP=0, next transfer OKAY.
- Address 0x0001_0004 with ADDR_WIDTH=14 -> word index wraps to 1.

Source files
------------

// File: rtl/ahb_bram_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane decode for ahb_bram_ctrl.
package ahb_bram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD       = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] mask;
        logic       illegal;
    } lane_t;

    // Illegal transfers return an all-zero mask so they can never reach the RAM.
    function automatic lane_t lane_decode(input logic [2:0] size, input logic [1:0] addr_lo);
        lane_t r;
        r.mask    = 4'b0000;
        r.illegal = 1'b0;
        case (size)
            HSIZE_BYTE: r.mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                r.mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                r.illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                r.mask    = 4'b1111;
                r.illegal = (addr_lo != 2'b00);
            end
            default: r.illegal = 1'b1;
        endcase
        r.mask = r.illegal ? 4'b0000 : r.mask;
        return r;
    endfunction

endpackage

// File: rtl/ahb_bram_lane_dec.sv
// Combinational byte-lane mask and illegal-transfer decode from HSIZE and HADDR[1:0].
module ahb_bram_lane_dec
    import ahb_bram_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    lane_t dec_s;

    // Decode the address-phase size and alignment.
    always_comb begin
        dec_s = lane_decode(hsize, haddr_lo);
    end

    assign mask    = dec_s.mask;
    assign illegal = dec_s.illegal;

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM (write port A, registered read port B).
// Optional macro BRAM_BYPASS_EN forwards write data into a colliding read instead of stalling.
module ahb_bram_ctrl
    import ahb_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
)
(
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [3:0]            bram_wea,
    output logic [31:0]           bram_dina,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [3:0]              mask_r;
    logic                    hready_r;
    logic                    hresp_r;

    logic [ADDR_WIDTH-1:0]   haddr_idx_s;
    logic                    accept_s;
    logic [3:0]              dec_mask_s;
    logic                    dec_illegal_s;
    logic                    hazard_s;
    logic                    stall_s;
    logic [31:0]             hrdata_s;
    logic                    unused_s;

    assign haddr_idx_s = HADDR[ADDR_WIDTH+1:2];
    assign accept_s    = HSEL & HREADY & HTRANS[1];
    assign unused_s    = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    ahb_bram_lane_dec u_lane_dec (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[1:0]),
        .mask     (dec_mask_s),
        .illegal  (dec_illegal_s)
    );

    // A legal read addressed while the same word is being written sees stale RAM data.
    always_comb begin
        if (accept_s && !HWRITE && !dec_illegal_s && (state_r == ST_WR) && (addr_r == haddr_idx_s)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

`ifdef BRAM_BYPASS_EN
    assign stall_s = 1'b0;
`else
    assign stall_s = hazard_s;
`endif

    // Transfer FSM with registered bus responses.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            mask_r   <= 4'b0000;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
        end else begin
            case (state_r)
                ST_RD_STALL: begin
                    state_r  <= ST_RD;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state_r  <= ST_ERR2;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_ERROR;
                end
                default: begin
                    if (accept_s) begin
                        addr_r <= haddr_idx_s;
                        mask_r <= dec_mask_s;
                        if (dec_illegal_s) begin
                            state_r  <= ST_ERR1;
                            hready_r <= 1'b0;
                            hresp_r  <= HRESP_ERROR;
                        end else if (HWRITE) begin
                            state_r  <= ST_WR;
                            hready_r <= 1'b1;
                            hresp_r  <= HRESP_OKAY;
                        end else if (stall_s) begin
                            state_r  <= ST_RD_STALL;
                            hready_r <= 1'b0;
                            hresp_r  <= HRESP_OKAY;
                        end else begin
                            state_r  <= ST_RD;
                            hready_r <= 1'b1;
                            hresp_r  <= HRESP_OKAY;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        hready_r <= 1'b1;
                        hresp_r  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // RAM port drive; a stalled read re-presents its own address so the retry sees new data.
    always_comb begin
        bram_addra = addr_r;
        bram_dina  = HWDATA;
        if ((state_r == ST_WR) && !rst) begin
            bram_wea = mask_r;
        end else begin
            bram_wea = 4'b0000;
        end
        if (state_r == ST_RD_STALL) begin
            bram_addrb = addr_r;
        end else begin
            bram_addrb = haddr_idx_s;
        end
    end

`ifdef BRAM_BYPASS_EN
    logic        byp_valid_r;
    logic [3:0]  byp_mask_r;
    logic [31:0] byp_data_r;

    // Capture the in-flight write for a colliding read.
    always_ff @(posedge clka) begin
        if (rst) begin
            byp_valid_r <= 1'b0;
            byp_mask_r  <= 4'b0000;
            byp_data_r  <= 32'h0000_0000;
        end else begin
            byp_valid_r <= hazard_s;
            if (hazard_s) begin
                byp_mask_r <= mask_r;
                byp_data_r <= HWDATA;
            end
        end
    end

    // Merge forwarded lanes over the stale RAM word.
    always_comb begin
        hrdata_s = bram_doutb;
        for (int i = 0; i < 4; i++) begin
            if (byp_valid_r && byp_mask_r[i]) begin
                hrdata_s[8*i +: 8] = byp_data_r[8*i +: 8];
            end else begin
                hrdata_s[8*i +: 8] = bram_doutb[8*i +: 8];
            end
        end
    end
`else
    // Read data comes straight from the RAM.
    always_comb begin
        hrdata_s = bram_doutb;
    end
`endif

    assign HREADYOUT = hready_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_s;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl: directed cases plus random traffic against a word-array model.
module tb_ahb_bram_ctrl;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;
    localparam int NPRE  = 32;

    logic          clka = 1'b0;
    logic          rst;
    logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0]   HADDR, HWDATA, HRDATA, bram_dina, bram_doutb;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [AW-1:0] bram_addra, bram_addrb;
    logic [3:0]    bram_wea;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   mem [DEPTH];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pl_cnt   = 0;

    typedef struct packed {
        logic        sel;
        logic        act;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t tq[$];

    always #5 clka = ~clka;
    assign HREADY = HREADYOUT;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clka       (clka),
        .rst        (rst),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .bram_addra (bram_addra),
        .bram_wea   (bram_wea),
        .bram_dina  (bram_dina),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    function automatic logic [31:0] pat(input int k);
        return 32'h1357_9BDF ^ (32'(k) * 32'h0101_0101);
    endfunction

    function automatic logic legal(input logic [2:0] s, input logic [1:0] a);
        return (s == 3'd0) || (s == 3'd1 && !a[0]) || (s == 3'd2 && a == 2'd0);
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] s, input logic [1:0] a);
        if (s == 3'd0) return 4'b0001 << a;
        if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Block RAM stand-in: preload a few words, then read-first dual port.
    always @(posedge clka) begin
        if (pl_cnt < NPRE) begin
            ram[pl_cnt] <= pat(pl_cnt);
            pl_cnt      <= pl_cnt + 1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bram_wea[b]) ram[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
            end
        end
        bram_doutb <= ram[bram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sel, input logic act, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.act = act; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        tq.push_back(x);
    endtask

    // Issue the queued transfers back to back and check every data-phase cycle.
    task automatic run_queue();
        xfer_t       dp, cur;
        logic        dp_v, dp_err, dp_haz, prev_wr, ready_e;
        logic [31:0] exp_rd;
        logic [3:0]  dp_mask;
        int          dp_cyc, i, budget, prev_idx, idx;
        dp = '0; cur = '0; dp_v = 1'b0; dp_err = 1'b0; dp_haz = 1'b0; prev_wr = 1'b0;
        exp_rd = 32'h0; dp_mask = 4'h0; dp_cyc = 0; i = 0; prev_idx = 0; idx = 0;
        budget = tq.size() * 3 + 8;
        while ((i < tq.size() || dp_v) && budget > 0) begin
            budget--;
            @(posedge clka); #1;
            cur    = (i < tq.size()) ? tq[i] : xfer_t'('0);
            HSEL   = cur.sel;
            HTRANS = cur.act ? 2'b10 : 2'b00;
            HADDR  = cur.addr;
            HSIZE  = cur.size;
            HWRITE = cur.wr;
            HWDATA = (dp_v && dp.wr) ? dp.wdata : 32'($urandom());
            @(negedge clka);
            if (dp_v) begin
                dp_cyc++;
                ready_e = !((dp_err || dp_haz) && dp_cyc == 1);
                check("hreadyout", 32'(HREADYOUT), 32'(ready_e));
                check("hresp", 32'(HRESP), 32'(dp_err));
                if (dp.wr && !dp_err) begin
                    check("wea", 32'(bram_wea), 32'(dp_mask));
                    check("addra", 32'(bram_addra), 32'(widx(dp.addr)));
                    check("dina", bram_dina, dp.wdata);
                end else begin
                    check("wea_off", 32'(bram_wea), 32'h0);
                end
                if (!dp.wr && !dp_err && ready_e) check("hrdata", HRDATA, exp_rd);
                if (ready_e) dp_v = 1'b0;
            end else begin
                check("idle_ready", 32'(HREADYOUT), 32'h1);
                check("idle_resp", 32'(HRESP), 32'h0);
                check("idle_wea", 32'(bram_wea), 32'h0);
            end
            if (HREADYOUT === 1'b1) begin
                if (i < tq.size()) i++;
                if (cur.sel && cur.act) begin
                    idx     = widx(cur.addr);
                    dp      = cur;
                    dp_v    = 1'b1;
                    dp_cyc  = 0;
                    dp_err  = !legal(cur.size, cur.addr[1:0]);
                    dp_mask = lanes(cur.size, cur.addr[1:0]);
                    dp_haz  = 1'b0;
`ifndef BRAM_BYPASS_EN
                    dp_haz  = !dp_err && !cur.wr && prev_wr && (prev_idx == idx);
`endif
                    exp_rd  = mem[idx];
                    if (!dp_err && cur.wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (dp_mask[b]) mem[idx][8*b +: 8] = cur.wdata[8*b +: 8];
                        end
                    end
                    prev_wr  = !dp_err && cur.wr;
                    prev_idx = idx;
                end else begin
                    prev_wr = 1'b0;
                end
            end
        end
        check("drain", 32'(i < tq.size() || dp_v), 32'h0);
        tq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] hi;
        logic [4:0]  w;
        logic [1:0]  lo;
        logic [2:0]  sz;
        int          r;
        rst = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd0;
        HWRITE = 1'b0; HWDATA = 32'h0;
        for (int k = 0; k < NPRE; k++) mem[k] = pat(k);
        repeat (NPRE + 8) @(posedge clka);
        @(negedge clka);
        check("rst_ready", 32'(HREADYOUT), 32'h1);
        check("rst_resp", 32'(HRESP), 32'h0);
        check("rst_wea", 32'(bram_wea), 32'h0);
        @(posedge clka); #1;
        rst = 1'b0;

        // word write, idle, read back
        push(1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        push(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
        run_queue();

        // byte merge into lane 3
        push(1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344);
        push(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        push(1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0013, 32'hABAB_ABAB);
        push(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
        run_queue();

        // write immediately followed by read of the same word
        push(1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0020, 32'h5566_7788);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0);
        run_queue();

        // misaligned word write, oversize read, then confirm the word is untouched
        push(1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0022, 32'h0BAD_0BAD);
        push(1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_0030, 32'h0);
        push(1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_0021, 32'hFFFF_FFFF);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0);
        run_queue();

        // address wraps modulo the RAM depth
        push(1'b1, 1'b1, 1'b1, 3'd2, 32'h0001_0004, 32'hA5A5_5A5A);
        push(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0004, 32'h0);
        run_queue();

        // reset during a write data phase drops the write
        @(posedge clka); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0040; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge clka); #1;
        rst = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hCAFE_F00D;
        @(negedge clka);
        check("rstmid_wea", 32'(bram_wea), 32'h0);
        check("rstmid_ready", 32'(HREADYOUT), 32'h1);
        check("rstmid_resp", 32'(HRESP), 32'h0);
        @(posedge clka); #1;
        rst = 1'b0;
        @(negedge clka);
        check("post_rst_ready", 32'(HREADYOUT), 32'h1);
        check("post_rst_resp", 32'(HRESP), 32'h0);
        push(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
        run_queue();

        // random traffic over a small window with random upper address bits
        for (int k = 0; k < 250; k++) begin
            r  = $urandom_range(0, 9);
            hi = 16'($urandom());
            w  = 5'($urandom_range(0, 7));
            lo = 2'($urandom_range(0, 3));
            sz = (r == 9) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (r < 7) begin
                if (sz == 3'd1) lo[0] = 1'b0;
                if (sz == 3'd2) lo = 2'b00;
            end
            push(r != 1, r != 0, 1'($urandom_range(0, 1)), sz, {hi, 9'b0, w, lo}, $urandom());
        end
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
